// File: rtl/platform_scroll_scheduler.sv
// platform_scroll_scheduler
// Sequences the platform row store: after reset it lays out every row from
// TOP_Y downwards, then once per frame (on vblank_start) walks all rows,
// applies the latched scroll and recycles rows that dropped below the screen
// back to the top with a fresh activation mask. One row write per cycle.
// Optional feature: define DIFFICULTY_RAMP_EN to let the allowed run of empty
// recycled rows grow with the total number of recycled rows.
module platform_scroll_scheduler #(
  parameter int ROWS      = 31,
  parameter int COLS      = 3,
  parameter int ROW_PITCH = 30,
  parameter int TOP_Y     = -450,
  parameter int SCREEN_H  = 480,
  parameter int MAX_EMPTY = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    vblank_start,
  input  logic [5:0]              scroll_px,
  input  logic [15:0]             rand_bits,
  output logic                    wr_en,
  output logic [$clog2(ROWS)-1:0] wr_row,
  output logic signed [10:0]      wr_y,
  output logic [COLS-1:0]         wr_active,
  output logic                    busy,
  output logic                    done,
  output logic                    overrun,
  output logic [15:0]             recycled_cnt
);

  localparam int RW = $clog2(ROWS);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
  localparam logic signed [11:0] SCREEN_H_S = 12'(SCREEN_H);
  localparam logic signed [11:0] WRAP_SPAN = 12'(ROWS * ROW_PITCH);
  localparam logic [COLS-1:0] ALL_ONES = {COLS{1'b1}};

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_SCAN = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t                 state_r;
  logic [RW-1:0]          cur_r;
  logic signed [10:0]     row_y_r [ROWS];
  logic [COLS-1:0]        row_act_r [ROWS];
  logic [2:0]             empty_run_r;
  logic [5:0]             scroll_r;

  logic signed [11:0]     sum_s;
  logic signed [11:0]     wrap_s;
  logic                   recycle_s;
  logic signed [10:0]     init_y_s;
  logic [2:0]             limit_s;
  logic [COLS+2:0]        act_s;
  logic [COLS-1:0]        act_mask_s;
  logic [2:0]             act_run_s;
  logic                   unused_rand_s;

  // ACT rule: returns {mask, next empty_run}. An all-zero draw is allowed
  // only while the empty run is below the limit; otherwise a single column
  // picked by rb[7:4] is forced on so the player always has a platform.
  function automatic logic [COLS+2:0] act_rule(input logic [15:0] rb,
                                               input logic [2:0]  run,
                                               input logic [2:0]  lim);
    logic [COLS-1:0] m;
    logic [3:0]      col;
    logic [COLS-1:0] one_hot;
    m       = rb[COLS-1:0];
    col     = 4'(rb[7:4] % 4'(COLS));
    one_hot = {{(COLS-1){1'b0}}, 1'b1} << col;
    if (m != {COLS{1'b0}}) begin
      return {m, 3'd0};
    end else if (run >= lim) begin
      return {one_hot, 3'd0};
    end else begin
      return {m, run + 3'd1};
    end
  endfunction

  // Upper random bits are not part of the ACT rule.
  assign unused_rand_s = ^rand_bits[15:8];

`ifdef DIFFICULTY_RAMP_EN
  logic [15:0] ramp_s;
  // Empty-run limit grows by one per 64 recycled rows, capped at +3.
  always_comb begin
    ramp_s = recycled_cnt >> 6;
    if (ramp_s > 16'd3) begin
      limit_s = 3'(MAX_EMPTY + 3);
    end else begin
      limit_s = 3'(MAX_EMPTY) + ramp_s[2:0];
    end
  end
`else
  // Constant empty-run limit.
  always_comb begin
    limit_s = 3'(MAX_EMPTY);
  end
`endif

  // Next-row arithmetic shared by INIT and SCAN.
  always_comb begin
    sum_s      = 12'(signed'({row_y_r[cur_r][10], row_y_r[cur_r]})) + signed'({6'd0, scroll_r});
    wrap_s     = sum_s - WRAP_SPAN;
    recycle_s  = (sum_s >= SCREEN_H_S);
    init_y_s   = 11'(TOP_Y + ROW_PITCH * int'(cur_r));
    act_s      = act_rule(rand_bits, empty_run_r, limit_s);
    act_mask_s = act_s[COLS+2:3];
    act_run_s  = act_s[2:0];
  end

  // Main FSM: row layout, frame scan, status and registered write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_INIT;
      cur_r        <= '0;
      wr_en        <= 1'b0;
      wr_row       <= '0;
      wr_y         <= 11'sd0;
      wr_active    <= '0;
      busy         <= 1'b1;
      done         <= 1'b0;
      overrun      <= 1'b0;
      recycled_cnt <= 16'd0;
      empty_run_r  <= 3'd0;
      scroll_r     <= 6'd0;
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      if (vblank_start && (state_r != ST_IDLE)) begin
        overrun <= 1'b1;
      end
      case (state_r)
        ST_INIT: begin
          wr_en           <= 1'b1;
          wr_row          <= cur_r;
          wr_y            <= init_y_s;
          row_y_r[cur_r]  <= init_y_s;
          if (cur_r == LAST_ROW) begin
            wr_active        <= ALL_ONES;
            row_act_r[cur_r] <= ALL_ONES;
            empty_run_r      <= 3'd0;
            state_r          <= ST_IDLE;
          end else begin
            wr_active        <= act_mask_s;
            row_act_r[cur_r] <= act_mask_s;
            empty_run_r      <= act_run_s;
            cur_r            <= cur_r + 1'b1;
          end
        end
        ST_IDLE: begin
          busy <= 1'b0;
          if (vblank_start) begin
            scroll_r <= scroll_px;
            busy     <= 1'b1;
            cur_r    <= '0;
            if (scroll_px == 6'd0) begin
              state_r <= ST_DONE;
            end else begin
              state_r <= ST_SCAN;
            end
          end
        end
        ST_SCAN: begin
          wr_en  <= 1'b1;
          wr_row <= cur_r;
          if (recycle_s) begin
            wr_y             <= wrap_s[10:0];
            row_y_r[cur_r]   <= wrap_s[10:0];
            wr_active        <= act_mask_s;
            row_act_r[cur_r] <= act_mask_s;
            empty_run_r      <= act_run_s;
            if (recycled_cnt != 16'hFFFF) begin
              recycled_cnt <= recycled_cnt + 16'd1;
            end
          end else begin
            wr_y           <= sum_s[10:0];
            row_y_r[cur_r] <= sum_s[10:0];
            wr_active      <= row_act_r[cur_r];
          end
          if (cur_r == LAST_ROW) begin
            state_r <= ST_DONE;
          end else begin
            cur_r <= cur_r + 1'b1;
          end
        end
        ST_DONE: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_INIT;
          cur_r   <= '0;
          busy    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_platform_scroll_scheduler.sv
// Directed bench for platform_scroll_scheduler: reset layout, plain scroll,
// recycle wrap, forced column, zero scroll, overrun and reset mid-scan.
module tb_platform_scroll_scheduler;

  logic               clk;
  logic               rst;
  logic               vblank_start;
  logic [5:0]         scroll_px;
  logic [15:0]        rand_bits;
  logic               wr_en;
  logic [4:0]         wr_row;
  logic signed [10:0] wr_y;
  logic [2:0]         wr_active;
  logic               busy;
  logic               done;
  logic               overrun;
  logic [15:0]        recycled_cnt;

  int checks;
  int failures;

  logic               cap_en   [0:63];
  logic [4:0]         cap_row  [0:63];
  logic signed [10:0] cap_y    [0:63];
  logic [2:0]         cap_act  [0:63];
  logic               cap_done [0:63];
  logic               cap_busy [0:63];
  logic               cap_ovr  [0:63];

  platform_scroll_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .vblank_start (vblank_start),
    .scroll_px    (scroll_px),
    .rand_bits    (rand_bits),
    .wr_en        (wr_en),
    .wr_row       (wr_row),
    .wr_y         (wr_y),
    .wr_active    (wr_active),
    .busy         (busy),
    .done         (done),
    .overrun      (overrun),
    .recycled_cnt (recycled_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      failures = failures + 1;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic kick(input logic [5:0] sc);
    vblank_start = 1'b1;
    scroll_px    = sc;
    @(posedge clk); #1;
    vblank_start = 1'b0;
  endtask

  task automatic capture(input int n, input int vb_at, input int rst_at);
    for (int t = 1; t <= n; t++) begin
      vblank_start = (t == vb_at);
      rst          = (t == rst_at);
      @(posedge clk); #1;
      cap_en[t]   = wr_en;
      cap_row[t]  = wr_row;
      cap_y[t]    = wr_y;
      cap_act[t]  = wr_active;
      cap_done[t] = done;
      cap_busy[t] = busy;
      cap_ovr[t]  = overrun;
    end
    vblank_start = 1'b0;
    rst          = 1'b0;
  endtask

  function automatic int count_done(input int lo, input int hi);
    int c;
    c = 0;
    for (int t = lo; t <= hi; t++) if (cap_done[t]) c++;
    return c;
  endfunction

  function automatic int count_en(input int lo, input int hi);
    int c;
    c = 0;
    for (int t = lo; t <= hi; t++) if (cap_en[t]) c++;
    return c;
  endfunction

  initial begin
    logic signed [10:0] ey;
    checks       = 0;
    failures     = 0;
    rst          = 1'b1;
    vblank_start = 1'b0;
    scroll_px    = 6'd0;
    rand_bits    = 16'h0045;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_recycled", 32'(recycled_cnt), 32'd0);

    // INIT layout: row k at cycle k+1, y = -450 + 30k
    capture(34, 0, 0);
    for (int k = 0; k < 31; k++) begin
      ey = 11'(-450 + 30 * k);
      chk("init_en", 32'(cap_en[k+1]), 32'd1);
      chk("init_row", 32'(cap_row[k+1]), 32'(k));
      chk("init_y", 32'(cap_y[k+1]), 32'(ey));
    end
    chk("init_row0_mask", 32'(cap_act[1]), 32'd5);
    chk("init_row30_mask", 32'(cap_act[31]), 32'd7);
    chk("init_busy_last", 32'(cap_busy[31]), 32'd1);
    chk("init_busy_fall", 32'(cap_busy[32]), 32'd0);
    chk("init_en_after", 32'(cap_en[32]), 32'd0);
    chk("init_no_done", 32'(count_done(1, 34)), 32'd0);

    // Plain scroll of 20, no recycle
    kick(6'd20);
    capture(33, 0, 0);
    for (int k = 0; k < 31; k++) begin
      ey = 11'(-430 + 30 * k);
      chk("scan20_row", 32'(cap_row[k+1]), 32'(k));
      chk("scan20_y", 32'(cap_y[k+1]), 32'(ey));
      chk("scan20_mask", 32'(cap_act[k+1]), (k == 30) ? 32'd7 : 32'd5);
    end
    chk("scan20_busy1", 32'(cap_busy[1]), 32'd1);
    chk("scan20_en32", 32'(cap_en[32]), 32'd0);
    chk("scan20_done32", 32'(cap_done[32]), 32'd1);
    chk("scan20_done_cnt", 32'(count_done(1, 33)), 32'd1);
    chk("scan20_busy32", 32'(cap_busy[32]), 32'd0);
    chk("scan20_recycled", 32'(recycled_cnt), 32'd0);

    // Recycle wrap: row30 470+15=485 -> -445, fresh mask 010
    rand_bits = 16'h0042;
    kick(6'd15);
    capture(33, 0, 0);
    ey = -11'sd445;
    chk("wrap_row30_y", 32'(cap_y[31]), 32'(ey));
    chk("wrap_row30_mask", 32'(cap_act[31]), 32'd2);
    ey = 11'sd455;
    chk("wrap_row29_y", 32'(cap_y[30]), 32'(ey));
    chk("wrap_row29_mask", 32'(cap_act[30]), 32'd5);
    chk("wrap_recycled", 32'(recycled_cnt), 32'd1);

    // Forced column: three recycled rows with m=0, rand_bits[7:4]=4
    rand_bits = 16'h0040;
    kick(6'd30);
    capture(33, 0, 0);
    ey = -11'sd445;
    chk("force_a_y", 32'(cap_y[30]), 32'(ey));
    chk("force_a_mask", 32'(cap_act[30]), 32'd0);
    chk("force_a_recycled", 32'(recycled_cnt), 32'd2);
    kick(6'd30);
    capture(33, 0, 0);
    chk("force_b_mask", 32'(cap_act[29]), 32'd0);
    kick(6'd30);
    capture(33, 0, 0);
    chk("force_c_y", 32'(cap_y[28]), 32'(ey));
    chk("force_c_mask", 32'(cap_act[28]), 32'd2);
    ey = -11'sd415;
    chk("force_c_row28_y", 32'(cap_y[29]), 32'(ey));
    chk("force_c_row28_mask", 32'(cap_act[29]), 32'd0);
    chk("force_recycled", 32'(recycled_cnt), 32'd4);

    // Zero scroll: done one cycle after vblank_start, no writes
    kick(6'd0);
    capture(4, 0, 0);
    chk("zero_done1", 32'(cap_done[1]), 32'd1);
    chk("zero_done2", 32'(cap_done[2]), 32'd0);
    chk("zero_no_wr", 32'(count_en(1, 4)), 32'd0);
    chk("zero_overrun", 32'(overrun), 32'd0);

    // Overrun: second vblank_start mid-scan with a different scroll is ignored
    kick(6'd1);
    scroll_px = 6'd50;
    capture(34, 5, 0);
    ey = -11'sd354;
    chk("ovr_row30_y", 32'(cap_y[31]), 32'(ey));
    chk("ovr_done32", 32'(cap_done[32]), 32'd1);
    chk("ovr_done_cnt", 32'(count_done(1, 34)), 32'd1);
    chk("ovr_wr_cnt", 32'(count_en(1, 34)), 32'd31);
    chk("ovr_flag", 32'(overrun), 32'd1);

    // Reset at cycle 10 of a scan: no done, INIT restarts from TOP_Y
    rand_bits = 16'h0045;
    kick(6'd1);
    capture(45, 0, 10);
    chk("rstscan_no_done", 32'(count_done(1, 45)), 32'd0);
    chk("rstscan_en10", 32'(cap_en[10]), 32'd0);
    chk("rstscan_ovr10", 32'(cap_ovr[10]), 32'd0);
    chk("rstscan_busy10", 32'(cap_busy[10]), 32'd1);
    for (int k = 0; k < 31; k++) begin
      ey = 11'(-450 + 30 * k);
      chk("rstscan_row", 32'(cap_row[k+11]), 32'(k));
      chk("rstscan_y", 32'(cap_y[k+11]), 32'(ey));
    end
    chk("rstscan_row30_mask", 32'(cap_act[41]), 32'd7);
    chk("rstscan_busy_fall", 32'(cap_busy[42]), 32'd0);
    chk("rstscan_overrun", 32'(overrun), 32'd0);
    chk("rstscan_recycled", 32'(recycled_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
